fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the decode/control unit.
- Holds the fetch PC and issues word requests to instruction memory over a valid/ready request channel, accepting in-order responses.
- Buffers fetched words with their PCs and presents them to decode over a valid/ready channel.
- Handles redirects from branch/jump resolution by flushing the buffer and discarding stale in-flight responses.

---
 rtl/fetch_unit.sv | 163 ++++++++++++++++
 tb/tb_fetch_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the decode/control unit.
// Ports: clk, rst_n (sync, active-low); imem_req_* request channel;
//        imem_resp_* in-order responses; inst_* decode channel;
//        redirect_* taken branch/jump target (flush and refetch).
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_RESET,
        S_FETCH,
        S_DRAIN
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] count;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;

    logic [31:0]   buf_inst [DEPTH];
    logic [31:0]   buf_pc   [DEPTH];

    logic          req_fire;
    logic          pop;
    logic          resp_keep;
    logic          resp_drop;
    logic [CW:0]   in_use;
    logic [CW-1:0] drop_on_redirect;
    logic [31:0]   redirect_target;

    // Credit: in-flight requests plus buffered words never exceed DEPTH,
    // so every kept response is guaranteed a free buffer slot.
    assign in_use    = {1'b0, outstanding} + {1'b0, count};
    assign req_fire  = imem_req_valid & imem_req_ready;
    assign pop       = inst_valid & inst_ready;
    assign resp_drop = imem_resp_valid & (drop_cnt != '0);
    assign resp_keep = imem_resp_valid & (drop_cnt == '0);

    // A response landing in the redirect cycle is itself stale, so it
    // is excluded from the count still to be discarded.
    assign drop_on_redirect = outstanding - CW'(imem_resp_valid);
    assign redirect_target  = redirect_pc & ~32'h0000_0003;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_RESET;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a redirect overrides normal drain progress
    always_comb begin
        state_next = state;
        unique case (state)
            S_RESET: begin
                state_next = S_FETCH;
            end
            S_FETCH: begin
                if (redirect_valid && drop_on_redirect != '0) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (redirect_valid) begin
                    state_next = (drop_on_redirect != '0) ? S_DRAIN : S_FETCH;
                end else if (resp_drop && drop_cnt == CW'(1)) begin
                    state_next = S_FETCH;
                end
            end
            default: begin
                state_next = S_RESET;
            end
        endcase
    end

    // Outputs
    always_comb begin
        imem_req_valid = (state != S_RESET) & ~redirect_valid
                       & (in_use < (CW+1)'(DEPTH));
        imem_req_addr  = fetch_pc;
        inst_valid     = (count != '0) & ~redirect_valid;
        inst_out       = buf_inst[head];
        inst_pc        = buf_pc[head];
    end

    // PCs, counters and buffer pointers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            count       <= '0;
            head        <= '0;
            tail        <= '0;
        end else if (redirect_valid) begin
            fetch_pc    <= redirect_target;
            resp_pc     <= redirect_target;
            outstanding <= drop_on_redirect;
            drop_cnt    <= drop_on_redirect;
            count       <= '0;
            head        <= '0;
            tail        <= '0;
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            outstanding <= outstanding + CW'(req_fire)
                         - CW'(imem_resp_valid);
            if (resp_drop) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
            if (resp_keep) begin
                resp_pc <= resp_pc + 32'd4;
                tail    <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            count <= count + CW'(resp_keep) - CW'(pop);
        end
    end

    // Buffer storage; cleared on reset so the head reads 0 / RESET_PC
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_inst[i] <= '0;
                buf_pc[i]   <= RESET_PC;
            end
        end else if (!redirect_valid && resp_keep) begin
            buf_inst[tail] <= imem_resp_data;
            buf_pc[tail]   <= resp_pc;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit.
// u0: RESET_PC=0, DEPTH=2; u1: RESET_PC=FFFF_FFF8, DEPTH=4.
module tb_fetch_unit;

    localparam logic [31:0] K = 32'h5A5A_0F0F;

    typedef struct {
        logic        rv;
        logic [31:0] ra;
        logic        iv;
        logic [31:0] ip;
    } exp_t;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        rq_rdy = 1'b1;
    logic        in_rdy = 1'b1;
    logic        rd_v   = 1'b0;
    logic [31:0] rd_pc  = 32'h0;
    int          lat    = 1;

    logic [1:0]  rv;
    logic [1:0]  iv;
    logic [31:0] ra [2];
    logic [31:0] io [2];
    logic [31:0] ip [2];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_u
        localparam logic [31:0] RPC = (g == 0) ? 32'h0 : 32'hFFFF_FFF8;
        localparam int          DP  = (g == 0) ? 2 : 4;

        logic        rs_v   = 1'b0;
        logic [31:0] rs_d   = 32'h0;
        logic        fire_s = 1'b0;
        logic        rst_s  = 1'b0;
        logic [31:0] adr_s  = 32'h0;
        logic [31:0] aq [$];
        int          dq [$];
        int          mc     = 0;

        fetch_unit #(
            .RESET_PC(RPC),
            .DEPTH   (DP)
        ) u_dut (
            .clk            (clk),
            .rst_n          (rst_n),
            .imem_req_valid (rv[g]),
            .imem_req_ready (rq_rdy),
            .imem_req_addr  (ra[g]),
            .imem_resp_valid(rs_v),
            .imem_resp_data (rs_d),
            .inst_valid     (iv[g]),
            .inst_ready     (in_rdy),
            .inst_out       (io[g]),
            .inst_pc        (ip[g]),
            .redirect_valid (rd_v),
            .redirect_pc    (rd_pc)
        );

        // Memory: sample the handshake mid-cycle, answer lat cycles later
        always @(negedge clk) begin
            fire_s = rv[g] & rq_rdy;
            adr_s  = ra[g];
            rst_s  = rst_n;
        end

        always @(posedge clk) begin
            #1;
            mc++;
            if (!rst_s) begin
                aq.delete();
                dq.delete();
            end else if (fire_s) begin
                aq.push_back(adr_s);
                dq.push_back(mc + lat - 1);
            end
            rs_v = 1'b0;
            rs_d = 32'h0;
            if (dq.size() != 0 && dq[0] <= mc) begin
                rs_v = 1'b1;
                rs_d = aq[0] ^ K;
                void'(aq.pop_front());
                void'(dq.pop_front());
            end
        end
    end

    // Expected per-cycle tables (cycle 1 = first edge with rst_n=1)
    exp_t t1u0 [7] = '{
        '{1'b1, 32'h0,  1'b0, 32'h0}, '{1'b1, 32'h4,  1'b0, 32'h0},
        '{1'b0, 32'h0,  1'b1, 32'h0}, '{1'b1, 32'h8,  1'b1, 32'h4},
        '{1'b1, 32'hC,  1'b0, 32'h0}, '{1'b0, 32'h0,  1'b1, 32'h8},
        '{1'b1, 32'h10, 1'b1, 32'hC}};
    exp_t t1u1 [7] = '{
        '{1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0},
        '{1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0},
        '{1'b1, 32'h0,  1'b1, 32'hFFFF_FFF8},
        '{1'b1, 32'h4,  1'b1, 32'hFFFF_FFFC},
        '{1'b1, 32'h8,  1'b1, 32'h0},
        '{1'b1, 32'hC,  1'b1, 32'h4},
        '{1'b1, 32'h10, 1'b1, 32'h8}};
    exp_t t2u0 [9] = '{
        '{1'b1, 32'h0, 1'b0, 32'h0}, '{1'b1, 32'h4, 1'b0, 32'h0},
        '{1'b0, 32'h0, 1'b1, 32'h0}, '{1'b0, 32'h0, 1'b1, 32'h0},
        '{1'b0, 32'h0, 1'b1, 32'h0}, '{1'b0, 32'h0, 1'b1, 32'h0},
        '{1'b1, 32'h8, 1'b1, 32'h4}, '{1'b1, 32'hC, 1'b0, 32'h0},
        '{1'b0, 32'h0, 1'b1, 32'h8}};
    exp_t t3u0 [10] = '{
        '{1'b1, 32'h0,   1'b0, 32'h0}, '{1'b1, 32'h4,   1'b0, 32'h0},
        '{1'b0, 32'h0,   1'b0, 32'h0}, '{1'b0, 32'h0,   1'b0, 32'h0},
        '{1'b1, 32'h100, 1'b0, 32'h0}, '{1'b1, 32'h104, 1'b0, 32'h0},
        '{1'b0, 32'h0,   1'b0, 32'h0}, '{1'b0, 32'h0,   1'b0, 32'h0},
        '{1'b0, 32'h0,   1'b1, 32'h100},
        '{1'b1, 32'h108, 1'b1, 32'h104}};
    exp_t t4u0 [8] = '{
        '{1'b1, 32'h0,   1'b0, 32'h0}, '{1'b1, 32'h4,   1'b0, 32'h0},
        '{1'b0, 32'h0,   1'b0, 32'h0}, '{1'b0, 32'h0,   1'b0, 32'h0},
        '{1'b1, 32'h200, 1'b0, 32'h0}, '{1'b1, 32'h204, 1'b0, 32'h0},
        '{1'b0, 32'h0,   1'b0, 32'h0}, '{1'b0, 32'h0,   1'b1, 32'h200}};
    exp_t t4u1 [8] = '{
        '{1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0},
        '{1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0},
        '{1'b1, 32'h0,   1'b0, 32'h0}, '{1'b0, 32'h0,   1'b0, 32'h0},
        '{1'b1, 32'h200, 1'b0, 32'h0}, '{1'b1, 32'h204, 1'b0, 32'h0},
        '{1'b1, 32'h208, 1'b0, 32'h0}, '{1'b1, 32'h20C, 1'b1, 32'h200}};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_e(input string nm, input int g, input exp_t e);
        chk({nm, ".rv"}, 32'(rv[g]), 32'(e.rv));
        if (e.rv) chk({nm, ".ra"}, ra[g], e.ra);
        chk({nm, ".iv"}, 32'(iv[g]), 32'(e.iv));
        if (e.iv) begin
            chk({nm, ".ip"}, ip[g], e.ip);
            chk({nm, ".io"}, io[g], e.ip ^ K);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic chk_rst(input string nm);
        chk({nm, ".u0.rv"}, 32'(rv[0]), 32'h0);
        chk({nm, ".u0.iv"}, 32'(iv[0]), 32'h0);
        chk({nm, ".u0.io"}, io[0], 32'h0);
        chk({nm, ".u0.ip"}, ip[0], 32'h0);
        chk({nm, ".u1.rv"}, 32'(rv[1]), 32'h0);
        chk({nm, ".u1.iv"}, 32'(iv[1]), 32'h0);
        chk({nm, ".u1.io"}, io[1], 32'h0);
        chk({nm, ".u1.ip"}, ip[1], 32'hFFFF_FFF8);
    endtask

    task automatic do_reset(input string nm);
        rst_n = 1'b0;
        nxt();
        nxt();
        rst_n = 1'b1;
        smp();
        chk_rst(nm);
    endtask

    initial begin
        // Streaming from reset, latency 1; u1 covers the PC wrap
        lat = 1; in_rdy = 1'b1;
        do_reset("t1.rst");
        for (int c = 1; c <= 7; c++) begin
            nxt(); smp();
            chk_e($sformatf("t1.u0.c%0d", c), 0, t1u0[c-1]);
            chk_e($sformatf("t1.u1.c%0d", c), 1, t1u1[c-1]);
        end

        // Decode stalled: credit stops at two, then drains in order
        in_rdy = 1'b0;
        do_reset("t2.rst");
        for (int c = 1; c <= 9; c++) begin
            nxt();
            if (c == 6) in_rdy = 1'b1;
            smp();
            chk_e($sformatf("t2.u0.c%0d", c), 0, t2u0[c-1]);
        end

        // Latency 3, redirect with two requests in flight
        lat = 3; in_rdy = 1'b1;
        do_reset("t3.rst");
        for (int c = 1; c <= 10; c++) begin
            nxt();
            if (c == 3) begin rd_v = 1'b1; rd_pc = 32'h103; end
            if (c == 4) rd_v = 1'b0;
            smp();
            chk_e($sformatf("t3.u0.c%0d", c), 0, t3u0[c-1]);
        end

        // Redirect coinciding with a response and a non-empty buffer
        lat = 2; in_rdy = 1'b1;
        do_reset("t4.rst");
        for (int c = 1; c <= 8; c++) begin
            nxt();
            if (c == 4) begin rd_v = 1'b1; rd_pc = 32'h200; end
            if (c == 5) rd_v = 1'b0;
            smp();
            chk_e($sformatf("t4.u0.c%0d", c), 0, t4u0[c-1]);
            chk_e($sformatf("t4.u1.c%0d", c), 1, t4u1[c-1]);
        end

        // One-cycle reset with a full buffer and requests in flight
        lat = 1; in_rdy = 1'b0;
        do_reset("t6.rst0");
        for (int c = 1; c <= 6; c++) begin
            nxt();
            if (c == 5) rst_n = 1'b0;
            if (c == 6) begin rst_n = 1'b1; in_rdy = 1'b1; end
            smp();
            if (c == 5) begin
                chk("t6.full.iv", 32'(iv[0]), 32'h1);
                chk("t6.full.ip", ip[0], 32'h0);
                chk("t6.full.rv", 32'(rv[0]), 32'h0);
                chk("t6.u1.iv", 32'(iv[1]), 32'h1);
            end
            if (c == 6) chk_rst("t6.rst1");
        end
        for (int c = 1; c <= 3; c++) begin
            nxt(); smp();
            chk_e($sformatf("t6.u0.c%0d", c), 0, t1u0[c-1]);
            chk_e($sformatf("t6.u1.c%0d", c), 1, t1u1[c-1]);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
